// File: rtl/fleet_pkg.sv
// Shared types and helpers for the monster fleet controller.
// Slot states, LFSR constants, popcount and rotating priority search.
package fleet_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_ACTIVE,
    SLOT_EXPLODING,
    SLOT_DEAD
  } slot_state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } search_t;

  function automatic logic [5:0] popcount(
    input logic [31:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  // First set bit of req[n-1:0] at or after start,
  // wrapping modulo n.
  function automatic search_t rr_search(
    input logic [31:0] req,
    input int          start,
    input int          n
  );
    search_t r;
    int      j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n && !r.found) begin
        j = (start + i) % n;
        if (req[j]) begin
          r.found = 1'b1;
          r.idx   = 5'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/monster_slot_fsm.sv
// Lifecycle of one fleet slot: IDLE -> ACTIVE -> EXPLODING -> DEAD.
// In: clk_i, rst_i, tick_i, spawn_i, hit_i, clear_i. Out: state_o, accepted_hit_o.
module monster_slot_fsm
  import fleet_pkg::*;
#(
  parameter int EXPLODE_FRAMES = 10,
  parameter int FRAME_CNT_W    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        spawn_i,
  input  logic        hit_i,
  input  logic        clear_i,
  output slot_state_t state_o,
  output logic        accepted_hit_o
);

  localparam logic [FRAME_CNT_W-1:0] EXP_LOAD =
    FRAME_CNT_W'(EXPLODE_FRAMES - 1);

  slot_state_t            state_q;
  logic [FRAME_CNT_W-1:0] cnt_q;

  // A clear in the same cycle wins over the hit.
  assign accepted_hit_o = hit_i & ~clear_i &
                          (state_q == SLOT_ACTIVE);
  assign state_o = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SLOT_IDLE;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= SLOT_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        SLOT_IDLE: begin
          if (spawn_i) state_q <= SLOT_ACTIVE;
        end
        SLOT_ACTIVE: begin
          if (hit_i) begin
            state_q <= SLOT_EXPLODING;
            cnt_q   <= EXP_LOAD;
          end
        end
        SLOT_EXPLODING: begin
          if (tick_i) begin
            if (cnt_q == '0) state_q <= SLOT_DEAD;
            else cnt_q <= cnt_q - FRAME_CNT_W'(1);
          end
        end
        SLOT_DEAD: begin
          state_q <= SLOT_DEAD;
        end
        default: state_q <= SLOT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/monster_fleet_controller.sv
// Fleet lifecycle, staggered spawn and round-robin fire scheduler.
// In: clk, resetN (active-high async), enable, startOfFrame, stage_start,
//   stage_amount, hit. Out: active, exploding, fire_pulse,
//   monster_died_pulse, died_count, alive_count, all_monsters_dead,
//   stage_busy. Option FLEET_FIRE_RANDOM_EN: LFSR offset on fire search.
module monster_fleet_controller
  import fleet_pkg::*;
#(
  parameter int MAX_MONSTERS   = 16,
  parameter int IDX_W          = $clog2(MAX_MONSTERS),
  parameter int EXPLODE_FRAMES = 10,
  parameter int SPAWN_INTERVAL = 4,
  parameter int FIRE_COOLDOWN  = 40,
  parameter int FRAME_CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    enable,
  input  logic                    startOfFrame,
  input  logic                    stage_start,
  input  logic [IDX_W:0]          stage_amount,
  input  logic [MAX_MONSTERS-1:0] hit,
  output logic [MAX_MONSTERS-1:0] active,
  output logic [MAX_MONSTERS-1:0] exploding,
  output logic [MAX_MONSTERS-1:0] fire_pulse,
  output logic                    monster_died_pulse,
  output logic [IDX_W:0]          died_count,
  output logic [IDX_W:0]          alive_count,
  output logic                    all_monsters_dead,
  output logic                    stage_busy
);

  localparam int N  = MAX_MONSTERS;
  localparam int AW = IDX_W + 1;
  localparam int CW = FRAME_CNT_W;

  localparam logic [CW-1:0] SPAWN_LOAD =
    CW'(SPAWN_INTERVAL - 1);
  localparam logic [CW-1:0] FIRE_LOAD =
    CW'(FIRE_COOLDOWN - 1);

  logic tick;

  logic [AW-1:0]    amount_q;
  logic [AW-1:0]    spawn_ptr_q;
  logic [CW-1:0]    spawn_tmr_q;
  logic [CW-1:0]    cool_q;
  logic [IDX_W-1:0] rr_q;

  logic [N-1:0]  active_q;
  logic [N-1:0]  exploding_q;
  logic [N-1:0]  fire_q;
  logic          died_pulse_q;
  logic [AW-1:0] died_count_q;
  logic [AW-1:0] alive_q;
  logic          all_dead_q;
  logic          busy_q;

  slot_state_t st [N];
  logic [N-1:0] act_v;
  logic [N-1:0] exp_v;
  logic [N-1:0] acc_v;
  logic [N-1:0] spawn_v;
  logic [N-1:0] fire_d;

  logic          busy;
  logic          spawn_go;
  logic          fire_go;
  logic [AW-1:0] amount_d;
  logic [AW-1:0] alive_now;
  logic [AW-1:0] died_now;
  int            start;
  search_t       srch;

  assign tick = startOfFrame & enable;
  assign busy = spawn_ptr_q < amount_q;

  assign amount_d = (stage_amount > AW'(N)) ?
                    AW'(N) : stage_amount;

  assign spawn_go = tick & ~stage_start & busy &
                    (spawn_tmr_q == '0);

`ifdef FLEET_FIRE_RANDOM_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      lfsr_q <= LFSR_SEED;
    end else if (lfsr_q[0]) begin
      lfsr_q <= (lfsr_q >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_q <= lfsr_q >> 1;
    end
  end

  assign start = int'(rr_q) + 1 +
                 int'(lfsr_q[IDX_W-1:0]);
`else
  assign start = int'(rr_q) + 1;
`endif

  always_comb begin
    act_v   = '0;
    exp_v   = '0;
    spawn_v = '0;
    for (int i = 0; i < N; i++) begin
      act_v[i] = (st[i] == SLOT_ACTIVE);
      exp_v[i] = (st[i] == SLOT_EXPLODING);
    end
    if (spawn_go) begin
      spawn_v[spawn_ptr_q[IDX_W-1:0]] = 1'b1;
    end
  end

  assign srch    = rr_search(32'(act_v), start, N);
  assign fire_go = tick & ~stage_start &
                   (cool_q == '0) & srch.found;

  always_comb begin
    fire_d = '0;
    if (fire_go) begin
      fire_d[IDX_W'(srch.idx)] = 1'b1;
    end
  end

  assign alive_now = AW'(popcount(32'(act_v | exp_v)));
  assign died_now  = AW'(popcount(32'(acc_v)));

  for (genvar g = 0; g < N; g++) begin : g_slot
    monster_slot_fsm #(
      .EXPLODE_FRAMES(EXPLODE_FRAMES),
      .FRAME_CNT_W   (FRAME_CNT_W)
    ) u_slot (
      .clk_i         (clk),
      .rst_i         (resetN),
      .tick_i        (tick),
      .spawn_i       (spawn_v[g]),
      .hit_i         (hit[g]),
      .clear_i       (stage_start),
      .state_o       (st[g]),
      .accepted_hit_o(acc_v[g])
    );
  end

  // Spawn, cooldown and round-robin pointer.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      amount_q    <= '0;
      spawn_ptr_q <= '0;
      spawn_tmr_q <= '0;
      cool_q      <= '0;
      rr_q        <= IDX_W'(N - 1);
    end else if (stage_start) begin
      amount_q    <= amount_d;
      spawn_ptr_q <= '0;
      spawn_tmr_q <= '0;
      cool_q      <= FIRE_LOAD;
    end else if (tick) begin
      if (spawn_go) begin
        spawn_ptr_q <= spawn_ptr_q + AW'(1);
        spawn_tmr_q <= SPAWN_LOAD;
      end else if (spawn_tmr_q != '0) begin
        spawn_tmr_q <= spawn_tmr_q - CW'(1);
      end
      // An empty search leaves the cooldown at 0 to retry.
      if (cool_q != '0) begin
        cool_q <= cool_q - CW'(1);
      end else if (fire_go) begin
        cool_q <= FIRE_LOAD;
        rr_q   <= IDX_W'(srch.idx);
      end
    end
  end

  // Registered view of the current fleet state.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      active_q     <= '0;
      exploding_q  <= '0;
      fire_q       <= '0;
      died_pulse_q <= 1'b0;
      died_count_q <= '0;
      alive_q      <= '0;
      all_dead_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      active_q     <= act_v;
      exploding_q  <= exp_v;
      fire_q       <= fire_d;
      died_pulse_q <= |acc_v;
      died_count_q <= died_now;
      alive_q      <= alive_now;
      all_dead_q   <= (amount_q != '0) & ~busy &
                      (alive_now == '0);
      busy_q       <= busy;
    end
  end

  assign active             = active_q;
  assign exploding          = exploding_q;
  assign fire_pulse         = fire_q;
  assign monster_died_pulse = died_pulse_q;
  assign died_count         = died_count_q;
  assign alive_count        = alive_q;
  assign all_monsters_dead  = all_dead_q;
  assign stage_busy         = busy_q;

endmodule

// File: tb/tb_monster_fleet_controller.sv
// Randomized bench for monster_fleet_controller against a
// behavioural fleet model.
module tb_monster_fleet_controller;

  localparam int MM = 16;
  localparam int EF = 10;
  localparam int SI = 4;
  localparam int FC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          sof;
  logic          ss;
  logic [4:0]    amt_in;
  logic [MM-1:0] hit;
  logic [MM-1:0] active;
  logic [MM-1:0] exploding;
  logic [MM-1:0] fire_pulse;
  logic          died_pulse;
  logic [4:0]    died_count;
  logic [4:0]    alive_count;
  logic          all_dead;
  logic          busy;

  always #5 clk = ~clk;

  monster_fleet_controller #(
    .MAX_MONSTERS  (MM),
    .EXPLODE_FRAMES(EF),
    .SPAWN_INTERVAL(SI),
    .FIRE_COOLDOWN (FC),
    .FRAME_CNT_W   (8)
  ) dut (
    .clk               (clk),
    .resetN            (rst),
    .enable            (enable),
    .startOfFrame      (sof),
    .stage_start       (ss),
    .stage_amount      (amt_in),
    .hit               (hit),
    .active            (active),
    .exploding         (exploding),
    .fire_pulse        (fire_pulse),
    .monster_died_pulse(died_pulse),
    .died_count        (died_count),
    .alive_count       (alive_count),
    .all_monsters_dead (all_dead),
    .stage_busy        (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  // Model: 0 idle, 1 active, 2 exploding, 3 dead.
  int ms [MM];
  int mc [MM];
  int m_amt = 0;
  int m_sp = 0;
  int m_tmr = 0;
  int m_cool = 0;
  int m_rr = MM - 1;

  logic [MM-1:0] e_act, e_exp, e_fire;
  int            e_died, e_alive;
  bit            e_pulse, e_dead, e_busy;
  bit            en_r = 1'b1;

  task automatic model_step(input bit s,
                            input int a,
                            input logic [MM-1:0] h,
                            input bit tk);
    logic [MM-1:0] acc;
    int  k;
    bit  fnd;
    e_act   = '0;
    e_exp   = '0;
    e_alive = 0;
    for (int i = 0; i < MM; i++) begin
      if (ms[i] == 1) e_act[i] = 1'b1;
      if (ms[i] == 2) e_exp[i] = 1'b1;
      if (ms[i] == 1 || ms[i] == 2) e_alive++;
    end
    e_busy = (m_sp < m_amt);
    e_dead = (m_amt != 0) && !e_busy && (e_alive == 0);
    e_fire = '0;
    acc    = '0;
    if (s) begin
      for (int i = 0; i < MM; i++) begin
        ms[i] = 0;
        mc[i] = 0;
      end
      m_sp   = 0;
      m_tmr  = 0;
      m_cool = FC - 1;
      m_amt  = (a > MM) ? MM : a;
    end else begin
      if (tk) begin
        if (m_cool == 0) begin
          fnd = 1'b0;
          for (int d = 1; d <= MM; d++) begin
            k = (m_rr + d) % MM;
            if (!fnd && ms[k] == 1) begin
              fnd       = 1'b1;
              e_fire[k] = 1'b1;
              m_rr      = k;
              m_cool    = FC - 1;
            end
          end
        end else begin
          m_cool--;
        end
      end
      for (int i = 0; i < MM; i++) begin
        if (ms[i] == 1 && h[i]) begin
          acc[i] = 1'b1;
          ms[i]  = 2;
          mc[i]  = EF - 1;
        end else if (ms[i] == 2 && tk) begin
          if (mc[i] == 0) ms[i] = 3;
          else mc[i]--;
        end
      end
      if (tk) begin
        if (m_tmr == 0 && m_sp < m_amt) begin
          ms[m_sp] = 1;
          m_sp++;
          m_tmr = SI - 1;
        end else if (m_tmr != 0) begin
          m_tmr--;
        end
      end
    end
    e_died  = $countones(acc);
    e_pulse = (acc != '0);
  endtask

  task automatic cycle(input bit s, input int a,
                       input logic [MM-1:0] h,
                       input bit f, input bit e);
    @(negedge clk);
    ss     = s;
    amt_in = 5'(a);
    hit    = h;
    sof    = f;
    enable = e;
    model_step(s, a, h, f & e);
    @(posedge clk);
    #1;
    chk("active", 32'(active), 32'(e_act));
    chk("exploding", 32'(exploding), 32'(e_exp));
    chk("fire_pulse", 32'(fire_pulse), 32'(e_fire));
    chk("died_count", 32'(died_count), 32'(e_died));
    chk("died_pulse", 32'(died_pulse), 32'(e_pulse));
    chk("alive_count", 32'(alive_count), 32'(e_alive));
    chk("all_dead", 32'(all_dead), 32'(e_dead));
    chk("stage_busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic rand_cycle();
    logic [MM-1:0] h;
    h = '0;
    if ($urandom_range(49) == 0) en_r = ~en_r;
    if ($urandom_range(7) == 0)
      h = MM'($urandom & $urandom & $urandom);
    cycle(1'b0, 0, h, 1'($urandom), en_r);
  endtask

  int amts [8] = '{4, 31, 0, 16, 7, 1, 20, 12};

  initial begin
    for (int i = 0; i < MM; i++) begin
      ms[i] = 0;
      mc[i] = 0;
    end
    rst    = 1'b1;
    enable = 1'b0;
    sof    = 1'b0;
    ss     = 1'b0;
    amt_in = '0;
    hit    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_fire", 32'(fire_pulse), 32'd0);
    chk("rst_alive", 32'(alive_count), 32'd0);
    chk("rst_dead", 32'(all_dead), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      // Slot 1 hit coincident with stage_start must be dropped.
      cycle(1'b1, amts[s],
            MM'($urandom) | MM'(2), 1'b1, 1'b1);
      for (int c = 0; c < 500; c++) rand_cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
